// File: rtl/match_scorer_pkg.sv
// Shared types and constants for the tug-of-war match scorer: FSM state
// encoding, winner codes and the active-low seven-segment digit table.
package match_pkg;

  typedef enum logic [1:0] {PLAY, HOLD, RESTART, MATCH_OVER} match_state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [1:0] WINNER_NONE  = 2'b00;
  localparam logic [1:0] WINNER_LEFT  = 2'b01;
  localparam logic [1:0] WINNER_RIGHT = 2'b10;

  // Bit order {g,f,e,d,c,b,a}, active low.
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

endpackage

// File: rtl/match_scorer_if.sv
// Signal bundle between the playfield side and the match scorer, plus the
// scorer's FSM state as a debug observation point.
interface match_scorer_if;
  import match_pkg::*;

  // win_left/win_right are single-cycle pulses with no back-pressure: the
  // scorer samples them every cycle and silently drops them outside PLAY.
  logic         win_left;
  logic         win_right;
  logic         round_reset;
  logic [6:0]   hex_left;
  logic [6:0]   hex_right;
  logic         match_over;
  logic [1:0]   match_winner;
  match_state_t state;

  modport master (
    output win_left, win_right,
    input  round_reset, hex_left, hex_right, match_over, match_winner, state
  );

  modport slave (
    input  win_left, win_right,
    output round_reset, hex_left, hex_right, match_over, match_winner, state
  );

endinterface

// File: rtl/match_scorer_seg7_decode.sv
// 4-bit value to active-low seven-segment pattern; values above 9 blank.
module seg7_decode
  import match_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (value <= 4'd9) seg = SEG_DIGIT[value];
  end

endmodule

// File: rtl/match_scorer.sv
// Match scorer: counts round wins, restarts the playfield after a hold-off
// and freezes on a match win. Optional winner-digit blink: SCORE_BLINK_EN.
module match_scorer
  import match_pkg::*;
#(
  parameter int WIN_SCORE   = 7,
  parameter int HOLD_CYCLES = 4
) (
  input  logic          Clock,
  input  logic          Reset,
  match_scorer_if.slave bus
);

  localparam int SW = $clog2(WIN_SCORE + 1);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [SW-1:0] WIN_VAL   = SW'(WIN_SCORE);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  match_state_t  state;
  logic [SW-1:0] score_l;
  logic [SW-1:0] score_r;
  logic [HW-1:0] hold_cnt;
  logic [1:0]    winner_q;

  logic          left_only;
  logic          right_only;
  logic [SW-1:0] winner_score;

  // Simultaneous wins are a tie and score nothing.
  assign left_only    = bus.win_left & ~bus.win_right;
  assign right_only   = bus.win_right & ~bus.win_left;
  assign winner_score = (winner_q == WINNER_LEFT) ? score_l : score_r;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= PLAY;
      score_l  <= '0;
      score_r  <= '0;
      hold_cnt <= '0;
      winner_q <= WINNER_NONE;
    end else begin
      case (state)
        PLAY: begin
          if (left_only) begin
            if (score_l != WIN_VAL) score_l <= score_l + 1'b1;
            winner_q <= WINNER_LEFT;
            hold_cnt <= '0;
            state    <= HOLD;
          end else if (right_only) begin
            if (score_r != WIN_VAL) score_r <= score_r + 1'b1;
            winner_q <= WINNER_RIGHT;
            hold_cnt <= '0;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state <= (winner_score == WIN_VAL) ? MATCH_OVER : RESTART;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        RESTART:    state <= PLAY;
        MATCH_OVER: state <= MATCH_OVER;
        default:    state <= PLAY;
      endcase
    end
  end

  logic [3:0] value_l;
  logic [3:0] value_r;
  logic [6:0] seg_l;
  logic [6:0] seg_r;

  assign value_l = 4'(score_l);
  assign value_r = 4'(score_r);

  seg7_decode u_dec_left  (.value(value_l), .seg(seg_l));
  seg7_decode u_dec_right (.value(value_r), .seg(seg_r));

`ifdef SCORE_BLINK_EN
  // Blank the round winner's digit on odd hold-off cycles.
  logic blink_off;
  assign blink_off     = (state == HOLD) && hold_cnt[0];
  assign bus.hex_left  = (blink_off && winner_q == WINNER_LEFT)  ? SEG_BLANK : seg_l;
  assign bus.hex_right = (blink_off && winner_q == WINNER_RIGHT) ? SEG_BLANK : seg_r;
`else
  assign bus.hex_left  = seg_l;
  assign bus.hex_right = seg_r;
`endif

  assign bus.round_reset  = (state == RESTART);
  assign bus.match_over   = (state == MATCH_OVER);
  assign bus.match_winner = (state == MATCH_OVER) ? winner_q : WINNER_NONE;
  assign bus.state        = state;

endmodule

// File: tb/tb_match_scorer.sv
// Randomised, self-checking bench for match_scorer (WIN_SCORE=3, HOLD_CYCLES=4)
// against a round-timeline reference model.
module tb_match_scorer;
  import match_pkg::*;

  localparam int WIN  = 3;
  localparam int HOLD = 4;
  localparam int W    = 18;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  match_scorer_if bus();

  match_scorer #(.WIN_SCORE(WIN), .HOLD_CYCLES(HOLD)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [6:0] digit_tab [0:9];

  // Model: scores, cycles left before play resumes, pending match end.
  int       m_l, m_r, m_lock;
  bit       m_final, m_over;
  logic [1:0] m_win;

  function automatic void model_edge(input logic wl, input logic wr);
    if (Reset) begin
      m_l = 0; m_r = 0; m_lock = 0; m_final = 0; m_over = 0; m_win = 2'b00;
    end else if (m_over) begin
    end else if (m_lock > 0) begin
      m_lock--;
      if (m_lock == 1 && m_final) begin
        m_over = 1; m_lock = 0;
      end
    end else if (wl ^ wr) begin
      if (wl) m_l++; else m_r++;
      m_win   = wl ? 2'b01 : 2'b10;
      m_final = ((wl ? m_l : m_r) == WIN);
      m_lock  = HOLD + 1;
    end
  endfunction

  function automatic logic [6:0] exp_hex(input bit left);
    logic [6:0] pat;
    pat = digit_tab[left ? m_l : m_r];
`ifdef SCORE_BLINK_EN
    if (m_lock >= 2 && m_win == (left ? 2'b01 : 2'b10) && ((HOLD + 1 - m_lock) % 2 == 1))
      pat = 7'b1111111;
`endif
    return pat;
  endfunction

  function automatic logic [W-1:0] exp_vec();
    return {exp_hex(1), exp_hex(0), (m_lock == 1), m_over, (m_over ? m_win : 2'b00)};
  endfunction

  task automatic tick(input logic wl, input logic wr);
    bus.win_left  = wl;
    bus.win_right = wr;
    @(posedge Clock);
    model_edge(wl, wr);
    @(negedge Clock);
    bus.win_left  = 1'b0;
    bus.win_right = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) tick(0, 0);
    Reset = 1'b0;
    tick(0, 0);
    checks++; if (bus.hex_left !== 7'b1000000) begin errors++; $display("FAIL reset_hex_left got %b want %b", bus.hex_left, 7'b1000000); end
    checks++; if (bus.hex_right !== 7'b1000000) begin errors++; $display("FAIL reset_hex_right got %b want %b", bus.hex_right, 7'b1000000); end
    checks++; if (bus.round_reset !== 1'b0) begin errors++; $display("FAIL reset_round_reset got %b want 0", bus.round_reset); end
    checks++; if (bus.match_over !== 1'b0) begin errors++; $display("FAIL reset_match_over got %b want 0", bus.match_over); end
    checks++; if (bus.match_winner !== 2'b00) begin errors++; $display("FAIL reset_match_winner got %b want 00", bus.match_winner); end
  endtask

  task automatic test_single_win();
    tick(1, 0);
    checks++; if (bus.hex_left !== exp_hex(1)) begin errors++; $display("FAIL win_hex_left_first got %b want %b", bus.hex_left, exp_hex(1)); end
    for (int k = 2; k <= HOLD + 2; k++) begin
      tick(0, 0);
      checks++;
      if (bus.round_reset !== (k == HOLD + 1)) begin
        errors++; $display("FAIL win_round_reset cycle t+%0d got %b want %b", k, bus.round_reset, (k == HOLD + 1));
      end
      checks++; if (bus.hex_left !== exp_hex(1)) begin errors++; $display("FAIL win_hex_left t+%0d got %b want %b", k, bus.hex_left, exp_hex(1)); end
`ifndef SCORE_BLINK_EN
      checks++; if (bus.hex_left !== 7'b1111001) begin errors++; $display("FAIL win_hex_steady t+%0d got %b want 1111001", k, bus.hex_left); end
`endif
    end
    checks++; if (bus.state !== PLAY) begin errors++; $display("FAIL win_back_to_play got %0d want %0d", bus.state, PLAY); end
  endtask

  task automatic test_ignored();
    tick(1, 0);
    for (int k = 1; k <= HOLD + 1; k++) begin
      tick(0, 1);
      checks++; if (bus.hex_right !== 7'b1000000) begin errors++; $display("FAIL ignored_hex_right step %0d got %b want 1000000", k, bus.hex_right); end
    end
    checks++; if (bus.hex_left !== 7'b0100100) begin errors++; $display("FAIL ignored_hex_left got %b want 0100100", bus.hex_left); end
    checks++; if (bus.state !== PLAY) begin errors++; $display("FAIL ignored_state got %0d want %0d", bus.state, PLAY); end
  endtask

  task automatic test_tie();
    tick(1, 1);
    tick(1, 1);
    for (int k = 0; k < HOLD + 2; k++) begin
      tick(0, 0);
      checks++; if (bus.round_reset !== 1'b0) begin errors++; $display("FAIL tie_round_reset step %0d got %b want 0", k, bus.round_reset); end
    end
    checks++; if (bus.hex_left !== 7'b0100100) begin errors++; $display("FAIL tie_hex_left got %b want 0100100", bus.hex_left); end
    checks++; if (bus.hex_right !== 7'b1000000) begin errors++; $display("FAIL tie_hex_right got %b want 1000000", bus.hex_right); end
  endtask

  task automatic test_match_win();
    Reset = 1'b1; tick(0, 0); Reset = 1'b0;
    for (int r = 0; r < WIN; r++) begin
      tick(0, 1);
      for (int i = 1; i <= HOLD; i++) begin
        tick(0, 0);
        checks++;
        if (bus.round_reset !== (i == HOLD && r < WIN - 1)) begin
          errors++; $display("FAIL match_round_reset round %0d step %0d got %b want %b", r, i, bus.round_reset, (i == HOLD && r < WIN - 1));
        end
      end
      if (r < WIN - 1) tick(0, 0);
    end
    checks++; if (bus.hex_right !== 7'b0110000) begin errors++; $display("FAIL match_hex_right got %b want 0110000", bus.hex_right); end
    checks++; if (bus.match_over !== 1'b1) begin errors++; $display("FAIL match_over got %b want 1", bus.match_over); end
    checks++; if (bus.match_winner !== 2'b10) begin errors++; $display("FAIL match_winner got %b want 10", bus.match_winner); end
    tick(1, 0); tick(0, 1); tick(1, 1);
    for (int k = 0; k < HOLD + 2; k++) begin
      tick(0, 0);
      checks++; if (bus.round_reset !== 1'b0) begin errors++; $display("FAIL frozen_round_reset step %0d got %b want 0", k, bus.round_reset); end
    end
    checks++; if (bus.hex_left !== 7'b1000000) begin errors++; $display("FAIL frozen_hex_left got %b want 1000000", bus.hex_left); end
    checks++; if (bus.match_over !== 1'b1) begin errors++; $display("FAIL frozen_match_over got %b want 1", bus.match_over); end
    Reset = 1'b1; tick(0, 0); Reset = 1'b0;
    checks++; if (bus.hex_right !== 7'b1000000) begin errors++; $display("FAIL rereset_hex_right got %b want 1000000", bus.hex_right); end
    checks++; if (bus.match_over !== 1'b0) begin errors++; $display("FAIL rereset_match_over got %b want 0", bus.match_over); end
    checks++; if (bus.match_winner !== 2'b00) begin errors++; $display("FAIL rereset_match_winner got %b want 00", bus.match_winner); end
  endtask

  task automatic test_random();
    logic [W-1:0] exp, got;
    int over_cycles;
    over_cycles = 0;
    for (int c = 0; c < 600; c++) begin
      if (m_over) over_cycles++;
      Reset = (over_cycles > 6) || ($urandom_range(0, 199) == 0);
      if (Reset) over_cycles = 0;
      tick(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      exp_q.push_back(exp_vec());
      got = {bus.hex_left, bus.hex_right, bus.round_reset, bus.match_over, bus.match_winner};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL random cycle %0d got %h want %h", c, got, exp);
      end
    end
    Reset = 1'b0;
  endtask

  initial begin
    digit_tab[0] = 7'b1000000; digit_tab[1] = 7'b1111001; digit_tab[2] = 7'b0100100;
    digit_tab[3] = 7'b0110000; digit_tab[4] = 7'b0011001; digit_tab[5] = 7'b0010010;
    digit_tab[6] = 7'b0000010; digit_tab[7] = 7'b1111000; digit_tab[8] = 7'b0000000;
    digit_tab[9] = 7'b0010000;
    bus.win_left  = 1'b0;
    bus.win_right = 1'b0;
    m_l = 0; m_r = 0; m_lock = 0; m_final = 0; m_over = 0; m_win = 2'b00;
    @(negedge Clock);
    test_reset();
    test_single_win();
    test_ignored();
    test_tie();
    test_match_win();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
